// File: rtl/draw_text.sv
// Scaled bitmap-font string renderer: one framebuffer write per cycle, glyph rows fetched from a font ROM.
// Optional macro DRAW_TEXT_CLIP_EN suppresses writes outside the visible screen area.
module draw_text #(
  parameter int PIXEL_X_WIDTH   = 10,
  parameter int PIXEL_Y_WIDTH   = 9,
  parameter int PIXEL_X_MAX     = 639,
  parameter int PIXEL_Y_MAX     = 479,
  parameter int H_RES           = 640,
  parameter int VGA_ADDR_WIDTH  = 19,
  parameter int COLOR_ID_WIDTH  = 8,
  parameter int CHAR_CODE_WIDTH = 8,
  parameter int GLYPH_W         = 5,
  parameter int GLYPH_H         = 9,
  parameter int MAX_LEN         = 16,
  parameter int LEN_WIDTH       = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       istart,
  input  logic [PIXEL_X_WIDTH-1:0]   x,
  input  logic [PIXEL_Y_WIDTH-1:0]   y,
  input  logic [LEN_WIDTH-1:0]       len,
  input  logic [3:0]                 scale,
  input  logic [COLOR_ID_WIDTH-1:0]  idata_fg,
  input  logic [COLOR_ID_WIDTH-1:0]  idata_bg,
  input  logic                       itransparent,
  output logic [LEN_WIDTH-1:0]       ochar_idx,
  input  logic [CHAR_CODE_WIDTH-1:0] ichar_code,
  output logic [CHAR_CODE_WIDTH-1:0] ofont_code,
  output logic [3:0]                 ofont_row,
  input  logic [GLYPH_W-1:0]         ifont_bits,
  output logic                       obusy,
  output logic                       odone,
  output logic [VGA_ADDR_WIDTH-1:0]  oaddr,
  output logic [COLOR_ID_WIDTH-1:0]  odata,
  output logic                       owren
);

  localparam int XW  = PIXEL_X_WIDTH + 1;
  localparam int YW  = PIXEL_Y_WIDTH + 1;
  localparam int UCW = $clog2(GLYPH_W + 1);
  localparam int URW = $clog2(GLYPH_H + 1);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, DRAW, DONE} state_t;

  state_t                    state;
  logic [XW-1:0]             cell_x_r;
  logic [XW-1:0]             px_r;
  logic [YW-1:0]             y_r;
  logic [YW-1:0]             py_r;
  logic [LEN_WIDTH-1:0]      len_r;
  logic [3:0]                scale_r;
  logic [COLOR_ID_WIDTH-1:0] fg_r;
  logic [COLOR_ID_WIDTH-1:0] bg_r;
  logic                      transp_r;
  logic [GLYPH_W-1:0]        bits_r;
  logic [UCW-1:0]            ucol_r;
  logic [3:0]                usub_r;
  logic [3:0]                uline_r;
  logic [URW-1:0]            urow_r;

  logic                      unit_end_s;
  logic                      line_end_s;
  logic                      adv_s;
  logic [UCW-1:0]            ucol_n_s;
  logic [XW-1:0]             cell_step_s;
  logic [XW-1:0]             wr_px_s;
  logic [YW-1:0]             wr_py_s;
  logic                      wr_fg_s;
  logic                      wr_en_s;
  logic [VGA_ADDR_WIDTH-1:0] wr_addr_s;
  logic [COLOR_ID_WIDTH-1:0] wr_data_s;

  // Unit column c (1..GLYPH_W) maps to bitmap bit GLYPH_W-c; column 0 is spacing.
  function automatic logic fg_bit(input logic [GLYPH_W-1:0] bits, input logic [UCW-1:0] ucol);
    logic r;
    r = 1'b0;
    for (int c = 1; c <= GLYPH_W; c++) begin
      r = (ucol == UCW'(c)) ? bits[GLYPH_W-c] : r;
    end
    return r;
  endfunction

  // Describe the pixel about to be entered, so its write is visible during its own DRAW cycle.
  always_comb begin
    unit_end_s  = (usub_r == scale_r);
    line_end_s  = (ucol_r == UCW'(GLYPH_W)) && unit_end_s;
    adv_s       = (state == DRAW) && !line_end_s;
    ucol_n_s    = unit_end_s ? ucol_r + UCW'(1) : ucol_r;
    cell_step_s = XW'((GLYPH_W + 1) * (32'(scale_r) + 32'd1));
    if (adv_s) begin
      wr_px_s = px_r + XW'(1);
      wr_py_s = py_r;
      wr_fg_s = fg_bit(bits_r, ucol_n_s);
    end else begin
      wr_px_s = cell_x_r;
      wr_py_s = (state == DRAW) ? py_r + YW'(1) : py_r;
      wr_fg_s = 1'b0;
    end
    wr_en_s = wr_fg_s || !transp_r;
`ifdef DRAW_TEXT_CLIP_EN
    if ((wr_px_s > XW'(PIXEL_X_MAX)) || (wr_py_s > YW'(PIXEL_Y_MAX))) begin
      wr_en_s = 1'b0;
    end else begin
      wr_en_s = wr_en_s;
    end
`endif
    if (wr_en_s) begin
      wr_addr_s = VGA_ADDR_WIDTH'(wr_py_s) * VGA_ADDR_WIDTH'(H_RES) + VGA_ADDR_WIDTH'(wr_px_s);
      wr_data_s = wr_fg_s ? fg_r : bg_r;
    end else begin
      wr_addr_s = '0;
      wr_data_s = '0;
    end
  end

  // Control FSM, scan counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cell_x_r   <= '0;
      px_r       <= '0;
      y_r        <= '0;
      py_r       <= '0;
      len_r      <= '0;
      scale_r    <= 4'd0;
      fg_r       <= '0;
      bg_r       <= '0;
      transp_r   <= 1'b0;
      bits_r     <= '0;
      ucol_r     <= '0;
      usub_r     <= 4'd0;
      uline_r    <= 4'd0;
      urow_r     <= '0;
      ochar_idx  <= '0;
      ofont_code <= '0;
      ofont_row  <= 4'd0;
      obusy      <= 1'b0;
      odone      <= 1'b0;
      oaddr      <= '0;
      odata      <= '0;
      owren      <= 1'b0;
    end else begin
      owren <= 1'b0;
      oaddr <= '0;
      odata <= '0;
      odone <= 1'b0;
      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (istart) begin
            cell_x_r   <= XW'(x);
            y_r        <= YW'(y);
            py_r       <= YW'(y);
            len_r      <= len;
            scale_r    <= scale;
            fg_r       <= idata_fg;
            bg_r       <= idata_bg;
            transp_r   <= itransparent;
            urow_r     <= '0;
            ofont_code <= ichar_code;
            ofont_row  <= 4'd0;
            if (len == LEN_WIDTH'(0)) begin
              state <= DONE;
              odone <= 1'b1;
            end else begin
              state <= FETCH;
              obusy <= 1'b1;
            end
          end
        end
        FETCH: state <= WAIT;
        WAIT: begin
          // Unit row 0 is the spacing row: its fetched bits are discarded.
          bits_r  <= (urow_r == URW'(0)) ? '0 : ifont_bits;
          px_r    <= cell_x_r;
          ucol_r  <= '0;
          usub_r  <= 4'd0;
          uline_r <= 4'd0;
          // Step the string index early so the next code is ready when the last row ends.
          if (urow_r == URW'(GLYPH_H)) ochar_idx <= ochar_idx + LEN_WIDTH'(1);
          owren <= wr_en_s;
          oaddr <= wr_addr_s;
          odata <= wr_data_s;
          state <= DRAW;
        end
        DRAW: begin
          if (!line_end_s) begin
            px_r <= px_r + XW'(1);
            if (unit_end_s) begin
              usub_r <= 4'd0;
              ucol_r <= ucol_n_s;
            end else begin
              usub_r <= usub_r + 4'd1;
            end
            owren <= wr_en_s;
            oaddr <= wr_addr_s;
            odata <= wr_data_s;
          end else if (uline_r != scale_r) begin
            uline_r <= uline_r + 4'd1;
            px_r    <= cell_x_r;
            py_r    <= py_r + YW'(1);
            ucol_r  <= '0;
            usub_r  <= 4'd0;
            owren   <= wr_en_s;
            oaddr   <= wr_addr_s;
            odata   <= wr_data_s;
          end else if (urow_r != URW'(GLYPH_H)) begin
            urow_r    <= urow_r + URW'(1);
            py_r      <= py_r + YW'(1);
            ofont_row <= 4'(urow_r);
            state     <= FETCH;
          end else if (ochar_idx != len_r) begin
            urow_r     <= '0;
            py_r       <= y_r;
            cell_x_r   <= cell_x_r + cell_step_s;
            ofont_code <= ichar_code;
            ofont_row  <= 4'd0;
            state      <= FETCH;
          end else begin
            ochar_idx <= '0;
            obusy     <= 1'b0;
            odone     <= 1'b1;
            state     <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_draw_text.sv
// Directed bench for draw_text: table of string renders plus reset, re-trigger and address corner cases.
module tb_draw_text;
  logic       clk = 1'b0;
  logic       rst, istart, itransparent;
  logic [9:0] x;
  logic [8:0] y;
  logic [4:0] len, ochar_idx, ifont_bits;
  logic [3:0] scale, ofont_row;
  logic [7:0] idata_fg, idata_bg, ichar_code, ofont_code, odata;
  logic       obusy, odone, owren;
  logic [18:0] oaddr;

  draw_text dut (
    .clk(clk), .rst(rst), .istart(istart), .x(x), .y(y), .len(len), .scale(scale),
    .idata_fg(idata_fg), .idata_bg(idata_bg), .itransparent(itransparent),
    .ochar_idx(ochar_idx), .ichar_code(ichar_code), .ofont_code(ofont_code),
    .ofont_row(ofont_row), .ifont_bits(ifont_bits), .obusy(obusy), .odone(odone),
    .oaddr(oaddr), .odata(odata), .owren(owren)
  );

  always #5 clk = ~clk;

  int font_sel = 1;
  assign ichar_code = 8'h41 + {3'b000, ochar_idx};

  function automatic logic [4:0] font(input int sel, input logic [7:0] code, input logic [3:0] row);
    case (sel)
      0: return 5'b00000;
      1: return 5'b10001;
      default: return code[4:0] ^ {1'b0, row};
    endcase
  endfunction

  // Font ROM with one cycle of latency.
  always @(posedge clk) ifont_bits <= font(font_sel, ofont_code, ofont_row);

  int n_checks = 0, n_fail = 0;
  int cyc = 0, start_cyc = 0;
  int nwr, nfg, nbad, last_wr_cyc, done_cyc, done_cnt, busy_rise, done_busy_bad;
  int last_addr;
  int cx, cy, clen, cu, ctr, cfg, cbg;
  logic [7:0] shadow [0:6399];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Independent pixel model: decode every write back into glyph coordinates.
  always @(negedge clk) begin
    int a, px, py, dx, dy, k, uc, ur, expd;
    logic [4:0] b;
    logic f;
    cyc++;
    if (owren) begin
      a = int'(oaddr);
      nwr++;
      last_addr = a;
      last_wr_cyc = cyc;
      if (a < 6400) shadow[a] = odata;
      px = a % 640; py = a / 640; dx = px - cx; dy = py - cy;
      if (dx < 0 || dy < 0 || dx >= clen * 6 * cu || dy >= 10 * cu) begin
        nbad++;
      end else begin
        k = dx / (6 * cu); uc = (dx % (6 * cu)) / cu; ur = dy / cu;
        b = font(font_sel, 8'(8'h41 + k), 4'(ur - 1));
        f = (ur >= 1 && uc >= 1) ? b[5 - uc] : 1'b0;
        expd = f ? cfg : cbg;
        if (int'(odata) != expd || (ctr != 0 && !f)) nbad++;
        if (f) nfg++;
      end
    end
    if (obusy && busy_rise < 0) busy_rise = cyc;
    if (odone) begin
      done_cnt++;
      done_cyc = cyc;
      if (obusy) done_busy_bad++;
    end
  end

  task automatic start(input int l, input int s, input int px0, input int py0, input int tr,
                       input int fgc, input int bgc);
    @(posedge clk); #1;
    x = 10'(px0); y = 9'(py0); len = 5'(l); scale = 4'(s); itransparent = tr[0];
    idata_fg = 8'(fgc); idata_bg = 8'(bgc); istart = 1'b1;
    cx = px0; cy = py0; clen = l; cu = s + 1; ctr = tr; cfg = fgc; cbg = bgc;
    nwr = 0; nfg = 0; nbad = 0; done_cnt = 0; busy_rise = -1; done_busy_bad = 0;
    last_addr = 0; start_cyc = cyc + 1; last_wr_cyc = start_cyc; done_cyc = -1;
    @(posedge clk); #1;
    istart = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 4000 && done_cnt == 0; i++) @(posedge clk);
    check({name, "_timeout"}, done_cnt > 0 ? 1 : 0, 1);
    repeat (4) @(posedge clk);
  endtask

  typedef struct {
    int len, scale, x, y, tr, sel, wr, fg, cycles, last, gap, busy;
  } vec_t;
  vec_t vecs [7];

  initial begin
    rst = 1'b1; istart = 1'b0; x = '0; y = '0; len = '0; scale = '0;
    idata_fg = '0; idata_bg = '0; itransparent = 1'b0;
    cx = 0; cy = 0; clen = 0; cu = 1; ctr = 0; cfg = 0; cbg = 0;
    nwr = 0; nfg = 0; nbad = 0; done_cnt = 0; busy_rise = -1; done_busy_bad = 0;
    vecs[0] = '{1, 0,   0,   0, 0, 1,  60,  18,   81,  5765,  1,  1};
    vecs[1] = '{2, 1, 100,  50, 0, 1, 480, 144,  521, 44283,  1,  1};
    vecs[2] = '{1, 0,   0,   0, 1, 0,   0,   0,   81,     0, 81,  1};
    vecs[3] = '{0, 0,   0,   0, 0, 1,   0,   0,    1,     0,  1, -1};
    vecs[4] = '{3, 0,  10,   5, 1, 2,  43,  43,  241,  8987,  1,  1};
    vecs[5] = '{1, 2,   0,   0, 0, 1, 540, 162,  561, 18577,  1,  1};
    vecs[6] = '{16, 0,  0, 100, 0, 1, 960, 288, 1281, 69855,  1,  1};
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk); #1;
    check("reset_outputs", int'({owren, odone, obusy, oaddr, odata, ochar_idx, ofont_code, ofont_row}), 0);

    for (int i = 0; i < 7; i++) begin
      font_sel = vecs[i].sel;
      start(vecs[i].len, vecs[i].scale, vecs[i].x, vecs[i].y, vecs[i].tr, 8'hA0 + i, 8'h50 + i);
      wait_done("vec");
      check("writes", nwr, vecs[i].wr);
      check("fg_writes", nfg, vecs[i].fg);
      check("pixel_errors", nbad, 0);
      check("done_cycle", done_cyc - start_cyc, vecs[i].cycles);
      check("done_pulses", done_cnt, 1);
      check("done_while_busy", done_busy_bad, 0);
      check("busy_rise", busy_rise < 0 ? -1 : busy_rise - start_cyc, vecs[i].busy);
      check("last_addr", last_addr, vecs[i].last);
      check("done_after_last_write", done_cyc - last_wr_cyc, vecs[i].gap);
    end

    // Row-1 line of a 10001 glyph at the origin.
    font_sel = 1;
    start(1, 0, 0, 0, 0, 8'hAA, 8'h55);
    wait_done("row1");
    check("addr640_bg", int'(shadow[640]), 8'h55);
    check("addr641_fg", int'(shadow[641]), 8'hAA);
    check("addr642_bg", int'(shadow[642]), 8'h55);
    check("addr645_fg", int'(shadow[645]), 8'hAA);

    // A second istart during the draw must be ignored.
    start(1, 0, 0, 0, 0, 8'hAA, 8'h55);
    repeat (20) @(posedge clk);
    #1 x = 10'd200; len = 5'd2; istart = 1'b1;
    @(posedge clk); #1 istart = 1'b0;
    wait_done("restart");
    check("restart_writes", nwr, 60);
    check("restart_cycles", done_cyc - start_cyc, 81);
    check("restart_pixels", nbad, 0);

    // Reset in the middle of a string.
    start(1, 0, 0, 0, 0, 8'hAA, 8'h55);
    while (cyc < start_cyc + 29) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); #1;
    check("midreset_outputs", int'({owren, odone, obusy, oaddr, odata, ochar_idx, ofont_code, ofont_row}), 0);
    nwr = 0;
    repeat (100) @(posedge clk);
    check("midreset_no_done", done_cnt, 0);
    check("midreset_no_writes", nwr, 0);
    start(1, 0, 0, 0, 0, 8'hAA, 8'h55);
    wait_done("after_reset");
    check("after_reset_writes", nwr, 60);
    check("after_reset_cycles", done_cyc - start_cyc, 81);

`ifdef DRAW_TEXT_CLIP_EN
    // Cell straddling the right screen edge: columns 640 and 641 are dropped.
    start(1, 0, 636, 0, 0, 8'hAA, 8'h55);
    wait_done("clip");
    check("clip_writes", nwr, 40);
    check("clip_cycles", done_cyc - start_cyc, 81);
    check("clip_pixels", nbad, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
